// File: rtl/slib_edge_filter_if.sv
// Edge filter signal bundle: synchronised levels, enables and clears in,
// filtered levels, edge pulses, sticky flags and interrupt out.
interface slib_edge_filter_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] re_en;
    logic [WIDTH-1:0] fe_en;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] fe;
    logic [WIDTH-1:0] flag;
    logic             irq;

    // Master supplies the line levels and control, slave is the filter.
    modport master (
        output d, re_en, fe_en, clr,
        input  lvl, re, fe, flag, irq
    );

    modport slave (
        input  d, re_en, fe_en, clr,
        output lvl, re, fe, flag, irq
    );
endinterface

// File: rtl/slib_edge_filter.sv
// Multi-channel glitch-filtered edge detector with registered edge pulses,
// sticky per-channel event flags and a combined interrupt.
module slib_edge_filter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned FILTER = 2
) (
    input logic               clk,
    input logic               rst,
    slib_edge_filter_if.slave bus
);
    localparam int unsigned    CntW   = $clog2(FILTER + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [WIDTH-1:0]           lvl_q, lvl_d;
    logic [WIDTH-1:0]           re_q, re_d;
    logic [WIDTH-1:0]           fe_q, fe_d;
    logic [WIDTH-1:0]           flag_q, flag_d;
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

    // Per-channel filter and flag next-state; channels never interact.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        re_d   = '0;
        fe_d   = '0;
        flag_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.d[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                // New level has held for FILTER edges: accept and pulse.
                lvl_d[i] = bus.d[i];
                cnt_d[i] = '0;
                re_d[i]  = bus.d[i];
                fe_d[i]  = ~bus.d[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
            // A qualified set on the same edge as a clear keeps the flag.
            flag_d[i] = (re_d[i] & bus.re_en[i]) | (fe_d[i] & bus.fe_en[i]) |
                        (flag_q[i] & ~bus.clr[i]);
        end
    end

    // State registers with synchronous reset that discards partial counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q  <= '0;
            cnt_q  <= '0;
            re_q   <= '0;
            fe_q   <= '0;
            flag_q <= '0;
        end else begin
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            re_q   <= re_d;
            fe_q   <= fe_d;
            flag_q <= flag_d;
        end
    end

    // Outputs come straight from registers so IRQ cannot glitch.
    always_comb begin
        bus.lvl  = lvl_q;
        bus.re   = re_q;
        bus.fe   = fe_q;
        bus.flag = flag_q;
        bus.irq  = |flag_q;
    end
endmodule
